cmp_minmax_sched: RTL and testbench

Frame-based min/max scheduler that time-shares a single `cmp` instance to find both the signed maximum and the signed minimum of a stream of `WORD_LEN`-bit words. Input arrives on a valid/ready stream. The block alternates the shared comparator between max mode and min mode for each word. When a frame ends, it presents `{max, min, count}` on a valid/ready result port. It sits in front of the int2fp normalisation logic, which consumes the frame range.

---
 rtl/cmp_minmax_sched.sv | 138 +++++++++++++
 tb/tb_cmp_minmax_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_sched.sv
// Frame min/max scheduler: one shared signed comparator alternates between
// max and min mode per word, then presents {max, min, count} per frame.
//
// state   | meaning
// IDLE    | waiting for first word; it seeds both max_r and min_r
// LOAD    | waiting for the next word into hold_r
// CMP_MAX | comparator in max mode, updates max_r
// CMP_MIN | comparator in min mode, updates min_r
// DONE    | result valid, held until downstream accepts

package modules_params_pkg;
  parameter int WORD_LEN = 16;
endpackage

module cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  input  logic         cmp_type_i,
  output logic [W-1:0] y_o
);
  logic x2_gt;
  logic x2_lt;

  // Strict compares so that ties return x1_i.
  assign x2_gt = $signed(x2_i) > $signed(x1_i);
  assign x2_lt = $signed(x2_i) < $signed(x1_i);
  assign y_o   = cmp_type_i ? (x2_gt ? x2_i : x1_i) : (x2_lt ? x2_i : x1_i);
endmodule

module cmp_minmax_sched
  import modules_params_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [WORD_LEN-1:0] s_data_i,
  input  logic                s_last_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [WORD_LEN-1:0] m_max_o,
  output logic [WORD_LEN-1:0] m_min_o,
  output logic [CNT_W-1:0]    m_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, CMP_MAX, CMP_MIN, DONE} state_t;

  state_t              state_r, state_n;
  logic [WORD_LEN-1:0] max_r, min_r, hold_r;
  logic [CNT_W-1:0]    cnt_r, cnt_inc;
  logic                end_r;
  logic                end_idle, end_load;
  logic                cmp_is_max;
  logic [WORD_LEN-1:0] cmp_x1, cmp_y;

  assign cnt_inc  = cnt_r + CNT_W'(1);
  assign end_idle = s_last_i || (CNT_W'(1) == CNT_W'(FRAME_LEN));
  assign end_load = s_last_i || (cnt_inc == CNT_W'(FRAME_LEN));

  assign cmp_is_max = (state_r == CMP_MAX);
  assign cmp_x1     = cmp_is_max ? max_r : min_r;

  cmp #(.W(WORD_LEN)) u_cmp (
    .x1_i      (cmp_x1),
    .x2_i      (hold_r),
    .cmp_type_i(cmp_is_max),
    .y_o       (cmp_y)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    case (state_r)
      IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i) state_n = end_idle ? DONE : LOAD;
      end
      LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i) state_n = CMP_MAX;
      end
      CMP_MAX: state_n = CMP_MIN;
      CMP_MIN: state_n = end_r ? DONE : LOAD;
      DONE: begin
        m_valid_o = 1'b1;
        if (m_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_r  <= '0;
      min_r  <= '0;
      hold_r <= '0;
      cnt_r  <= '0;
      end_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (s_valid_i) begin
          max_r <= s_data_i;
          min_r <= s_data_i;
          cnt_r <= CNT_W'(1);
        end
        LOAD: if (s_valid_i) begin
          hold_r <= s_data_i;
          cnt_r  <= cnt_inc;
          end_r  <= end_load;
        end
        CMP_MAX: max_r <= cmp_y;
        CMP_MIN: min_r <= cmp_y;
        DONE: if (m_ready_i) begin
          cnt_r <= '0;
          end_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registers are zero in reset, so the result port reads zero too.
  assign m_max_o = max_r;
  assign m_min_o = min_r;
  assign m_cnt_o = cnt_r;

endmodule

// File: tb/tb_cmp_minmax_sched.sv
// Randomized self-checking bench for cmp_minmax_sched against a frame-level
// min/max/count and latency model.
module tb_cmp_minmax_sched;
  import modules_params_pkg::*;

  localparam int W  = WORD_LEN;
  localparam int FL = 8;
  localparam int CW = $clog2(FL + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic [W-1:0]  s_data_i = '0;
  logic          s_ready_o, m_valid_o;
  logic [W-1:0]  m_max_o, m_min_o;
  logic [CW-1:0] m_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic signed [W-1:0] words[FL];
  bit                  lasts[FL];

  cmp_minmax_sched #(.FRAME_LEN(FL)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_max_o  (m_max_o),
    .m_min_o  (m_min_o),
    .m_cnt_o  (m_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Frame ends at the first flagged word or at FL words.
  function automatic void model(output logic signed [W-1:0] mx,
                                output logic signed [W-1:0] mn,
                                output int n);
    n = FL;
    for (int i = 0; i < FL; i++) if (lasts[i]) begin n = i + 1; break; end
    mx = words[0];
    mn = words[0];
    for (int i = 1; i < n; i++) begin
      if (words[i] > mx) mx = words[i];
      if (words[i] < mn) mn = words[i];
    end
  endfunction

  function automatic void clear_frame();
    for (int i = 0; i < FL; i++) begin words[i] = '0; lasts[i] = 1'b0; end
  endfunction

  task automatic run_frame(input int max_stall, input int bp, input string tag);
    logic signed [W-1:0] emx, emn;
    logic [W-1:0] hmx, hmn;
    int en, e0, t, st, stall_total, exp_seen;
    model(emx, emn, en);
    stall_total = 0;
    e0 = 0;
    for (int k = 0; k < en; k++) begin
      @(negedge clk_i);
      t = 0;
      while (!s_ready_o && t < 20) begin
        s_valid_i = 1'b0; s_last_i = 1'b0;
        @(negedge clk_i); t++;
      end
      checks++;
      if (s_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_wait word %0d: got %b expected 1", tag, k, s_ready_o);
      end
      if (k > 0 && max_stall > 0) begin
        st = $urandom_range(max_stall, 0);
        repeat (st) begin
          s_valid_i = 1'b0; s_last_i = $urandom_range(1, 0); s_data_i = $urandom;
          @(negedge clk_i);
          stall_total++;
        end
      end
      s_valid_i = 1'b1; s_data_i = words[k]; s_last_i = lasts[k];
      if (k == 0) e0 = cyc;
      else begin
        checks++;
        if (cyc !== e0 + 1 + 3 * (k - 1) + stall_total) begin
          errors++;
          $display("FAIL %s accept_edge word %0d: got %0d expected %0d", tag, k,
                   cyc - e0, 1 + 3 * (k - 1) + stall_total);
        end
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    s_valid_i = 1'b0; s_last_i = 1'b0;
    t = 0;
    while (!m_valid_o && t < 50) begin @(negedge clk_i); t++; end
    exp_seen = (en == 1) ? e0 + 1 : e0 + 3 * en - 2 + stall_total;
    checks++;
    if (!m_valid_o || cyc !== exp_seen) begin
      errors++;
      $display("FAIL %s latency: got valid=%b at %0d expected valid at %0d", tag,
               m_valid_o, cyc - e0, exp_seen - e0);
    end
    checks++;
    if (m_max_o !== emx || m_min_o !== emn || m_cnt_o !== CW'(en)) begin
      errors++;
      $display("FAIL %s result: got max=%0d min=%0d cnt=%0d expected max=%0d min=%0d cnt=%0d",
               tag, $signed(m_max_o), $signed(m_min_o), m_cnt_o, emx, emn, en);
    end
    hmx = m_max_o; hmn = m_min_o;
    repeat (bp) begin
      s_valid_i = 1'b1; s_data_i = $urandom;
      @(negedge clk_i);
      checks++;
      if (m_valid_o !== 1'b1 || s_ready_o !== 1'b0 || m_max_o !== hmx ||
          m_min_o !== hmn || m_cnt_o !== CW'(en)) begin
        errors++;
        $display("FAIL %s backpressure: got valid=%b ready=%b max=%0d cnt=%0d expected valid=1 ready=0 max=%0d cnt=%0d",
                 tag, m_valid_o, s_ready_o, $signed(m_max_o), m_cnt_o, $signed(hmx), en);
      end
    end
    m_ready_i = 1'b1;
    @(negedge clk_i);
    m_ready_i = 1'b0; s_valid_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || m_cnt_o !== '0) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b ready=%b cnt=%0d expected valid=0 ready=1 cnt=0",
               tag, m_valid_o, s_ready_o, m_cnt_o);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0 || m_max_o !== '0 ||
        m_min_o !== '0 || m_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset: got ready=%b valid=%b max=%0d min=%0d cnt=%0d expected 1 0 0 0 0",
               s_ready_o, m_valid_o, m_max_o, m_min_o, m_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_full_frame();
    int v[FL] = '{3, -7, 12, 0, 5, -1, 9, 2};
    clear_frame();
    for (int i = 0; i < FL; i++) words[i] = W'(v[i]);
    run_frame(0, 0, "full_frame");
  endtask

  task automatic test_single();
    clear_frame();
    words[0] = -4; lasts[0] = 1'b1;
    run_frame(0, 3, "single");
  endtask

  task automatic test_equal();
    clear_frame();
    words[0] = 5; words[1] = 5; words[2] = 5; lasts[2] = 1'b1;
    run_frame(0, 0, "equal");
  endtask

  task automatic test_extremes();
    logic [W-1:0] pos, neg;
    pos = {1'b0, {(W-1){1'b1}}};
    neg = {1'b1, {(W-1){1'b0}}};
    clear_frame();
    words[0] = pos; words[1] = neg; words[2] = -1; lasts[2] = 1'b1;
    run_frame(0, 0, "extremes");
    clear_frame();
    words[0] = -1; words[1] = neg; words[2] = pos; lasts[2] = 1'b1;
    run_frame(0, 0, "extremes_rev");
  endtask

  task automatic test_backpressure();
    clear_frame();
    words[0] = 7; words[1] = -3; lasts[1] = 1'b1;
    run_frame(0, 10, "backpressure");
  endtask

  task automatic test_last_on_final();
    clear_frame();
    for (int i = 0; i < FL; i++) words[i] = W'($urandom);
    lasts[FL-1] = 1'b1;
    run_frame(0, 0, "last_on_final");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk_i);
    s_valid_i = 1'b1; s_data_i = W'(100);
    @(negedge clk_i);
    s_data_i = W'(-100);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    s_valid_i = 1'b1; s_data_i = W'(55);
    #1;
    checks++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0 || m_max_o !== '0 ||
        m_min_o !== '0 || m_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ready=%b valid=%b max=%0d min=%0d cnt=%0d expected 1 0 0 0 0",
               s_ready_o, m_valid_o, m_max_o, m_min_o, m_cnt_o);
    end
    @(negedge clk_i);
    checks++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0 || m_max_o !== '0 || m_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_hold: got ready=%b valid=%b max=%0d cnt=%0d expected 1 0 0 0",
               s_ready_o, m_valid_o, m_max_o, m_cnt_o);
    end
    s_valid_i = 1'b0;
    rst_ni = 1'b1;
    clear_frame();
    words[0] = 1; words[1] = -2; lasts[1] = 1'b1;
    run_frame(0, 0, "after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 16; f++) begin
      clear_frame();
      n = $urandom_range(FL, 1);
      for (int i = 0; i < FL; i++) begin
        case ($urandom_range(7, 0))
          0:       words[i] = {1'b0, {(W-1){1'b1}}};
          1:       words[i] = {1'b1, {(W-1){1'b0}}};
          default: words[i] = W'($urandom);
        endcase
      end
      if ($urandom_range(3, 0) != 0) lasts[n-1] = 1'b1;
      run_frame(2, $urandom_range(3, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_single();
    test_equal();
    test_extremes();
    test_backpressure();
    test_last_on_final();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
